// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed BCD 7-segment display.
// Optional build macro LEAD_ZERO_BLANK_EN is consumed by bcd_scan_display.
package display_pkg;

  typedef enum logic [1:0] {
    S_UNI = 2'd0,
    S_DEZ = 2'd1,
    S_CEN = 2'd2
  } state_t;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [2:0] DIG_OFF = 3'b111;
  localparam logic [2:0] DIG_UNI = 3'b110;
  localparam logic [2:0] DIG_DEZ = 3'b101;
  localparam logic [2:0] DIG_CEN = 3'b011;

  // Active-low digit enable for whichever slot a state lights.
  function automatic logic [2:0] digEnable(input state_t s);
    logic [2:0] en;
    en = DIG_OFF;
    case (s)
      S_UNI:   en = DIG_UNI;
      S_DEZ:   en = DIG_DEZ;
      S_CEN:   en = DIG_CEN;
      default: en = DIG_OFF;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/bcd_scan_display_if.sv
// Digit-capture and display bus between the BCD source/board and the scanner.
// The master side drives the digits and load strobe; the slave drives the display pins.
interface bcd_scan_display_if;

  logic       load;
  logic [3:0] centenas;
  logic [3:0] dezenas;
  logic [3:0] unidades;
  logic [6:0] seg_n;
  logic [2:0] dig_n;

  modport master (
    output load, centenas, dezenas, unidades,
    input  seg_n, dig_n
  );

  modport slave (
    input  load, centenas, dezenas, unidades,
    output seg_n, dig_n
  );

endinterface

// File: rtl/driver7seg.sv
// BCD to active-low 7-segment decoder (bit0 = a ... bit6 = g).
// Non-BCD codes 10-15 show a dash so a bad upstream value is visible on the board.
module driver7seg
  import display_pkg::*;
(
  input  logic [3:0] b,
  output logic [6:0] d
);

  always_comb begin
    d = SEG_DASH;
    case (b)
      4'd0:    d = 7'h40;
      4'd1:    d = 7'h79;
      4'd2:    d = 7'h24;
      4'd3:    d = 7'h30;
      4'd4:    d = 7'h19;
      4'd5:    d = 7'h12;
      4'd6:    d = 7'h02;
      4'd7:    d = 7'h78;
      4'd8:    d = 7'h00;
      4'd9:    d = 7'h10;
      default: d = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Captures three BCD digits and time-multiplexes them onto one shared segment bus.
// Define LEAD_ZERO_BLANK_EN to blank leading-zero hundreds/tens digits.
module bcd_scan_display
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
)(
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_scan_display_if.slave    bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_tick;
  logic [3:0]         r_cen;
  logic [3:0]         r_dez;
  logic [3:0]         r_uni;
  logic               r_started;
  logic [6:0]         r_segN;
  logic [2:0]         r_digN;
  logic [3:0]         w_selDigit;
  logic [6:0]         w_decoded;
  logic               w_blank;

  assign w_tick = (r_cnt == CNT_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cen <= 4'd0;
      r_dez <= 4'd0;
      r_uni <= 4'd0;
    end else if (bus.load) begin
      r_cen <= bus.centenas;
      r_dez <= bus.dezenas;
      r_uni <= bus.unidades;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CEN;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (w_tick) begin
      case (r_state)
        S_UNI:   w_nextState = S_DEZ;
        S_DEZ:   w_nextState = S_CEN;
        default: w_nextState = S_UNI;
      endcase
    end
  end

  // Decode from the next state so segments and enables switch on the same edge.
  always_comb begin
    w_selDigit = r_uni;
    case (w_nextState)
      S_DEZ:   w_selDigit = r_dez;
      S_CEN:   w_selDigit = r_cen;
      default: w_selDigit = r_uni;
    endcase
  end

  driver7seg u_dec (
    .b (w_selDigit),
    .d (w_decoded)
  );

  always_comb begin
    w_blank = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
    if (w_nextState == S_CEN && r_cen == 4'd0) begin
      w_blank = 1'b1;
    end
    if (w_nextState == S_DEZ && r_cen == 4'd0 && r_dez == 4'd0) begin
      w_blank = 1'b1;
    end
`endif
  end

  // Display stays dark until the first refresh tick after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started <= 1'b0;
      r_segN    <= SEG_OFF;
      r_digN    <= DIG_OFF;
    end else if (r_started || w_tick) begin
      r_started <= 1'b1;
      r_segN    <= w_blank ? SEG_OFF : w_decoded;
      r_digN    <= digEnable(w_nextState);
    end else begin
      r_segN    <= SEG_OFF;
      r_digN    <= DIG_OFF;
    end
  end

  assign bus.seg_n = r_segN;
  assign bus.dig_n = r_digN;

endmodule
